// File: rtl/mf_pkg.sv
// Shared matched-filter definitions: widths, tap type, FSM states, saturating negate.
package mf_pkg;

  localparam int unsigned COEF_W = 16;

  typedef struct packed {
    logic signed [COEF_W-1:0] re;
    logic signed [COEF_W-1:0] im;
  } coef_t;

  typedef enum logic {
    StIdle,
    StRun
  } state_e;

  // Two's-complement negate that clamps the most negative value to the most positive one.
  function automatic logic signed [COEF_W-1:0] sat_neg(input logic signed [COEF_W-1:0] x);
    if (x == {1'b1, {(COEF_W-1){1'b0}}}) begin
      return {1'b0, {(COEF_W-1){1'b1}}};
    end
    return -x;
  endfunction

endpackage

// File: rtl/mf_coef_bank_if.sv
// Load port and tap-stream handshake of the coefficient bank.
interface mf_coef_bank_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 6
);
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic signed [DATA_W-1:0] wr_re;
  logic signed [DATA_W-1:0] wr_im;
  logic                     wr_err;
  logic                     start;
  logic                     reverse;
  logic                     conj;
  logic signed [DATA_W-1:0] coef_re;
  logic signed [DATA_W-1:0] coef_im;
  logic                     coef_valid;
  logic                     coef_ready;
  logic                     coef_last;
  logic                     busy;

  modport slave (
    input  wr_en, wr_addr, wr_re, wr_im, start, reverse, conj, coef_ready,
    output wr_err, coef_re, coef_im, coef_valid, coef_last, busy
  );

  modport master (
    output wr_en, wr_addr, wr_re, wr_im, start, reverse, conj, coef_ready,
    input  wr_err, coef_re, coef_im, coef_valid, coef_last, busy
  );
endinterface

// File: rtl/mf_coef_mem.sv
// Dual real/imaginary tap storage: one synchronous write port, one asynchronous read port.
// Not reset, so loaded taps survive a reset of the control logic.
module mf_coef_mem #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 61,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic signed [DATA_W-1:0] wr_re,
  input  logic signed [DATA_W-1:0] wr_im,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic signed [DATA_W-1:0] rd_re,
  output logic signed [DATA_W-1:0] rd_im
);

  logic signed [DATA_W-1:0] mem_re [DEPTH];
  logic signed [DATA_W-1:0] mem_im [DEPTH];

  // Commit a tap; the caller guarantees wr_addr < DEPTH when wr_en is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_re[wr_addr] <= wr_re;
      mem_im[wr_addr] <= wr_im;
    end
  end

  assign rd_re = mem_re[rd_addr];
  assign rd_im = mem_im[rd_addr];

endmodule

// File: rtl/mf_coef_bank.sv
// Reloadable complex coefficient bank streaming all taps forward or reversed, optionally
// conjugated, over a valid/ready handshake.
module mf_coef_bank
  import mf_pkg::*;
#(
  parameter int unsigned DATA_W = COEF_W,
  parameter int unsigned DEPTH  = 61,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input logic           clk,
  input logic           rst,
  mf_coef_bank_if.slave bus
);

  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W + 1)'(DEPTH);

  state_e                   state_q, state_d;
  logic                     rev_q, rev_d;
  logic                     conj_q, conj_d;
  logic [ADDR_W-1:0]        idx_q, idx_d;
  logic [ADDR_W-1:0]        rd_addr;
  logic signed [DATA_W-1:0] rd_re, rd_im, rd_im_neg;
  logic signed [DATA_W-1:0] coef_re_q, coef_re_d;
  logic signed [DATA_W-1:0] coef_im_q, coef_im_d;
  logic                     valid_q, valid_d;
  logic                     last_q, last_d;
  logic                     wr_err_q, wr_err_d;
  logic                     load;
  logic                     wr_ok;

  // Writes only land while idle and in range; anything else is dropped and flagged.
  assign wr_ok    = bus.wr_en & (state_q == StIdle) & ({1'b0, bus.wr_addr} < DEPTH_W);
  assign wr_err_d = bus.wr_en & ~wr_ok;

  mf_coef_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_ok),
    .wr_addr (bus.wr_addr),
    .wr_re   (bus.wr_re),
    .wr_im   (bus.wr_im),
    .rd_addr (rd_addr),
    .rd_re   (rd_re),
    .rd_im   (rd_im)
  );

  if (DATA_W == COEF_W) begin : g_neg_pkg
    assign rd_im_neg = sat_neg(rd_im);
  end else begin : g_neg_gen
    localparam logic signed [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [DATA_W-1:0] MAX_VAL = {1'b0, {(DATA_W-1){1'b1}}};
    assign rd_im_neg = (rd_im == MIN_VAL) ? MAX_VAL : -rd_im;
  end

  // Sweep control: next state, index, read address and when the output register reloads.
  always_comb begin
    state_d = state_q;
    rev_d   = rev_q;
    conj_d  = conj_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    last_d  = last_q;
    load    = 1'b0;
    rd_addr = idx_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StRun;
          rev_d   = bus.reverse;
          conj_d  = bus.conj;
          idx_d   = bus.reverse ? IDX_LAST : ADDR_W'(0);
          load    = 1'b1;
        end
      end
      StRun: begin
        if (!valid_q) begin
          load = 1'b1;
        end else if (bus.coef_ready) begin
          if (last_q) begin
            state_d = StIdle;
            valid_d = 1'b0;
            last_d  = 1'b0;
          end else begin
            idx_d = rev_q ? (idx_q - ADDR_W'(1)) : (idx_q + ADDR_W'(1));
            load  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (load) begin
      rd_addr = idx_d;
      valid_d = 1'b1;
      last_d  = (idx_d == (rev_d ? ADDR_W'(0) : IDX_LAST));
    end
  end

  // Output data: capture the addressed tap on load, otherwise hold.
  always_comb begin
    coef_re_d = coef_re_q;
    coef_im_d = coef_im_q;
    if (load) begin
      coef_re_d = rd_re;
      coef_im_d = conj_d ? rd_im_neg : rd_im;
    end
  end

  // State and output registers; memory is deliberately outside this reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      rev_q     <= 1'b0;
      conj_q    <= 1'b0;
      idx_q     <= '0;
      coef_re_q <= '0;
      coef_im_q <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      wr_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rev_q     <= rev_d;
      conj_q    <= conj_d;
      idx_q     <= idx_d;
      coef_re_q <= coef_re_d;
      coef_im_q <= coef_im_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      wr_err_q  <= wr_err_d;
    end
  end

  assign bus.coef_re    = coef_re_q;
  assign bus.coef_im    = coef_im_q;
  assign bus.coef_valid = valid_q;
  assign bus.coef_last  = last_q;
  assign bus.busy       = (state_q == StRun);
  assign bus.wr_err     = wr_err_q;

endmodule

// File: tb/tb_mf_coef_bank.sv
// Self-checking bench for mf_coef_bank against an array-based model of the tap bank.
module tb_mf_coef_bank;
  import mf_pkg::*;

  localparam int DEPTH  = 61;
  localparam int ADDR_W = 6;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic signed [15:0] model_re [DEPTH];
  logic signed [15:0] model_im [DEPTH];

  mf_coef_bank_if #(.DATA_W(16), .ADDR_W(ADDR_W)) bus ();

  mf_coef_bank #(
    .DATA_W (16),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit                 in_run;
    int                 addr;
    logic signed [15:0] re;
    logic signed [15:0] im;
    bit                 exp_err;
  } wvec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic signed [15:0] m_conj(input logic signed [15:0] v);
    int x;
    x = -int'(v);
    if (x > 32767) x = 32767;
    return 16'(x);
  endfunction

  // Single idle write; wr_err is due in the following cycle exactly when addr is out of range.
  task automatic wr(input int addr, input logic signed [15:0] re, input logic signed [15:0] im);
    bus.wr_en   = 1'b1;
    bus.wr_addr = ADDR_W'(addr);
    bus.wr_re   = re;
    bus.wr_im   = im;
    tick();
    bus.wr_en = 1'b0;
    chk("wr_err_idle", {31'd0, bus.wr_err}, {31'd0, addr >= DEPTH});
    if (addr < DEPTH) begin
      model_re[addr] = re;
      model_im[addr] = im;
    end
  endtask

  // mode 0: ready high; 1: ready pattern 1,0,0 repeating; 2: random ready.
  task automatic run_sweep(input bit rev, input bit cj, input int mode, input bit do_wr,
                           input int waddr, input logic signed [15:0] wre,
                           input logic signed [15:0] wim, input bit noisy);
    logic signed [15:0] exp_re [$];
    logic signed [15:0] exp_im [$];
    int n;
    int cyc;
    bit rdy;
    if (do_wr) begin
      model_re[waddr] = wre;
      model_im[waddr] = wim;
    end
    for (int k = 0; k < DEPTH; k++) begin
      int i;
      i = rev ? DEPTH - 1 - k : k;
      exp_re.push_back(model_re[i]);
      exp_im.push_back(cj ? m_conj(model_im[i]) : model_im[i]);
    end
    bus.start   = 1'b1;
    bus.reverse = rev;
    bus.conj    = cj;
    if (do_wr) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = ADDR_W'(waddr);
      bus.wr_re   = wre;
      bus.wr_im   = wim;
    end
    tick();
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    n   = 0;
    cyc = 0;
    while (n < DEPTH && cyc < 20 * DEPTH) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bus.coef_ready = rdy;
      if (noisy) begin
        bus.start   = 1'($urandom_range(0, 1));
        bus.reverse = 1'($urandom_range(0, 1));
        bus.conj    = 1'($urandom_range(0, 1));
      end
      chk("sweep_valid", {31'd0, bus.coef_valid}, 32'd1);
      chk("sweep_busy", {31'd0, bus.busy}, 32'd1);
      chk("sweep_re", 32'(bus.coef_re), 32'(exp_re[n]));
      chk("sweep_im", 32'(bus.coef_im), 32'(exp_im[n]));
      chk("sweep_last", {31'd0, bus.coef_last}, {31'd0, n == DEPTH - 1});
      if (rdy && bus.coef_valid) n++;
      tick();
      cyc++;
    end
    bus.start      = 1'b0;
    bus.coef_ready = 1'b0;
    chk("sweep_taps_seen", n, DEPTH);
    chk("end_valid", {31'd0, bus.coef_valid}, 32'd0);
    chk("end_busy", {31'd0, bus.busy}, 32'd0);
    chk("end_last", {31'd0, bus.coef_last}, 32'd0);
  endtask

  initial begin
    wvec_t wv [6];
    int    cnt;
    checks   = 0;
    failures = 0;
    rst            = 1'b0;
    bus.wr_en      = 1'b0;
    bus.wr_addr    = '0;
    bus.wr_re      = '0;
    bus.wr_im      = '0;
    bus.start      = 1'b0;
    bus.reverse    = 1'b0;
    bus.conj       = 1'b0;
    bus.coef_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      model_re[i] = '0;
      model_im[i] = '0;
    end

    // Reset values.
    tick();
    tick();
    chk("rst_re", 32'(bus.coef_re), 32'd0);
    chk("rst_im", 32'(bus.coef_im), 32'd0);
    chk("rst_valid", {31'd0, bus.coef_valid}, 32'd0);
    chk("rst_last", {31'd0, bus.coef_last}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_wr_err", {31'd0, bus.wr_err}, 32'd0);
    #3 rst = 1'b1;
    tick();

    // Power-up contents, then a ramp loaded forward and reversed.
    run_sweep(1'b0, 1'b0, 0, 1'b0, 0, '0, '0, 1'b0);
    for (int k = 0; k < DEPTH; k++) wr(k, 16'(k), 16'(-k));
    run_sweep(1'b0, 1'b0, 0, 1'b0, 0, '0, '0, 1'b0);
    run_sweep(1'b1, 1'b0, 0, 1'b0, 0, '0, '0, 1'b0);

    // Write-port vectors: accepted, rejected in RUN, rejected out of range.
    wv[0] = '{1'b0, 5,  16'sh0005, 16'sh8000, 1'b0};
    wv[1] = '{1'b0, 6,  16'sh0006, 16'sh1234, 1'b0};
    wv[2] = '{1'b1, 7,  16'shAAAA, 16'sh5555, 1'b1};
    wv[3] = '{1'b0, 61, 16'shBEEF, 16'shBEEF, 1'b1};
    wv[4] = '{1'b0, 63, 16'sh7777, 16'sh7777, 1'b1};
    wv[5] = '{1'b1, 0,  16'sh1111, 16'sh2222, 1'b1};
    for (int v = 0; v < 6; v++) begin
      if (wv[v].in_run) begin
        bus.start      = 1'b1;
        bus.reverse    = 1'b0;
        bus.conj       = 1'b0;
        bus.coef_ready = 1'b0;
        tick();
        bus.start = 1'b0;
      end
      bus.wr_en   = 1'b1;
      bus.wr_addr = ADDR_W'(wv[v].addr);
      bus.wr_re   = wv[v].re;
      bus.wr_im   = wv[v].im;
      tick();
      bus.wr_en = 1'b0;
      chk("vec_wr_err", {31'd0, bus.wr_err}, {31'd0, wv[v].exp_err});
      tick();
      chk("vec_wr_err_pulse", {31'd0, bus.wr_err}, 32'd0);
      if (!wv[v].in_run && wv[v].addr < DEPTH) begin
        model_re[wv[v].addr] = wv[v].re;
        model_im[wv[v].addr] = wv[v].im;
      end
      if (wv[v].in_run) begin
        bus.coef_ready = 1'b1;
        cnt = 0;
        while (bus.busy && cnt < 4 * DEPTH) begin
          tick();
          cnt++;
        end
        bus.coef_ready = 1'b0;
        chk("vec_drain_busy", {31'd0, bus.busy}, 32'd0);
      end
    end

    // Conjugate with saturation, then a stalling consumer.
    run_sweep(1'b0, 1'b1, 0, 1'b0, 0, '0, '0, 1'b0);
    chk("model_conj_8000", 32'(m_conj(model_im[5])), 32'(16'sh7FFF));
    chk("model_conj_1234", 32'(m_conj(model_im[6])), 32'(16'shEDCC));
    run_sweep(1'b0, 1'b0, 1, 1'b0, 0, '0, '0, 1'b0);

    // Write in the same cycle as start, to a tap reached later in the sweep.
    run_sweep(1'b0, 1'b0, 0, 1'b1, 40, 16'sh4040, 16'sh0404, 1'b0);

    // Reset in the middle of a sweep.
    bus.start      = 1'b1;
    bus.reverse    = 1'b0;
    bus.conj       = 1'b0;
    bus.coef_ready = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 30; k++) tick();
    chk("mid_tap30_re", 32'(bus.coef_re), 32'(model_re[30]));
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, bus.coef_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("mid_rst_re", 32'(bus.coef_re), 32'd0);
    chk("mid_rst_im", 32'(bus.coef_im), 32'd0);
    chk("mid_rst_last", {31'd0, bus.coef_last}, 32'd0);
    bus.coef_ready = 1'b0;
    tick();
    tick();
    chk("mid_rst_hold_valid", {31'd0, bus.coef_valid}, 32'd0);
    #3 rst = 1'b1;
    tick();
    run_sweep(1'b0, 1'b0, 0, 1'b0, 0, '0, '0, 1'b0);

    // Random loads and sweeps with random ready and start noise while busy.
    for (int r = 0; r < 24; r++) begin
      wr(int'($urandom_range(0, 63)), 16'($urandom), 16'($urandom));
    end
    wr(20, 16'sh8000, 16'sh8000);
    for (int s = 0; s < 6; s++) begin
      run_sweep(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2, 1'b0, 0, '0, '0, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
